// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, one shift-add or restoring step per cycle
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIN
  } state_t;

  localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_IT  = CNT_W'(XLEN - 1);

  state_t            state_q, state_nx;
  logic [2*XLEN-1:0] acc_q, acc_nx;
  logic [XLEN-1:0]   opnd_q, opnd_nx;
  logic [2:0]        op_q, op_nx;
  logic              neg_q, neg_nx;
  logic [CNT_W-1:0]  cnt_q, cnt_nx;
  logic              busy_nx, done_nx, res_we;
  logic [XLEN-1:0]   result_nx;

  // Operand decode for a request presented in IDLE
  logic            a_signed, b_signed, a_sign, b_sign;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            in_neg;

  always_comb begin
    a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    a_sign   = a_signed & a[XLEN-1];
    b_sign   = b_signed & b[XLEN-1];
    a_mag    = a_sign ? -a : a;
    b_mag    = b_sign ? -b : b;
    in_neg   = (op[2] && op[1]) ? a_sign : (a_sign ^ b_sign);
    div_zero = op[2] && (b == '0);
    div_ovf  = op[2] && !op[0] && (a == MOST_NEG) && (b == '1);
    special  = div_zero || div_ovf;
  end

  // One iteration of either algorithm; the accumulator holds {hi, lo} or {rem, quo}
  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] mul_step, div_step, acc_step;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
    mul_step  = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
    div_step  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    acc_step  = (state_q == S_DIV) ? div_step : mul_step;
  end

  // Sign fix-up and result select; special cases enter already in final form
  logic [2*XLEN-1:0] fin_acc, prod_fix;
  logic [2:0]        fin_op;
  logic              fin_neg;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  always_comb begin
    if (state_q == S_IDLE) begin
      fin_acc = div_zero ? {a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, a};
      fin_op  = op;
      fin_neg = 1'b0;
    end else begin
      fin_acc = acc_step;
      fin_op  = op_q;
      fin_neg = neg_q;
    end
    prod_fix = fin_neg ? -fin_acc : fin_acc;
    quo_fix  = fin_neg ? -fin_acc[XLEN-1:0] : fin_acc[XLEN-1:0];
    rem_fix  = fin_neg ? -fin_acc[2*XLEN-1:XLEN] : fin_acc[2*XLEN-1:XLEN];
    case (fin_op)
      3'b000:                 result_nx = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result_nx = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result_nx = quo_fix;
      default:                result_nx = rem_fix;
    endcase
  end

  always_comb begin
    state_nx = state_q;
    acc_nx   = acc_q;
    opnd_nx  = opnd_q;
    op_nx    = op_q;
    neg_nx   = neg_q;
    cnt_nx   = cnt_q;
    res_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_nx  = op;
          neg_nx = in_neg;
          cnt_nx = '0;
          if (special) begin
            state_nx = S_FIN;
            res_we   = 1'b1;
          end else if (op[2]) begin
            state_nx = S_DIV;
            opnd_nx  = b_mag;
            acc_nx   = {{XLEN{1'b0}}, a_mag};
          end else begin
            state_nx = S_MUL;
            opnd_nx  = a_mag;
            acc_nx   = {{XLEN{1'b0}}, b_mag};
          end
        end
      end
      S_MUL, S_DIV: begin
        acc_nx = acc_step;
        cnt_nx = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_IT) begin
          state_nx = S_FIN;
          res_we   = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    // A flush abandons the operation before anything becomes visible
    if (flush && (state_q != S_IDLE)) begin
      state_nx = S_IDLE;
      res_we   = 1'b0;
    end
    busy_nx = (state_nx != S_IDLE);
    done_nx = (state_nx == S_FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      opnd_q  <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      state_q <= state_nx;
      acc_q   <= acc_nx;
      opnd_q  <= opnd_nx;
      op_q    <= op_nx;
      neg_q   <= neg_nx;
      cnt_q   <= cnt_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      if (res_we) begin
        result <= result_nx;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed-vector bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

  muldiv_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the unit idle; returns at the negedge after done where busy must be low
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
    int k;
    int nbusy;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a     = ~x;
    b     = y ^ 32'h5a5a_a5a5;
    k     = 1;
    nbusy = 0;
    while (!done && k < 200) begin
      if (busy) nbusy++;
      @(negedge clk);
      k++;
    end
    if (busy) nbusy++;
    check({tag, ".lat"}, k, exp_lat);
    check({tag, ".res"}, result, exp);
    check({tag, ".busy_cycles"}, nbusy, exp_lat);
    @(negedge clk);
    check({tag, ".busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    int k;
    logic [31:0] old;
    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = 3'b000;
    a     = 32'h1234_5678;
    b     = 32'h9abc_def0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op("mul_7x6", OP_MUL, 32'd7, 32'd6, 32'd42, 33);
    repeat (6) @(negedge clk);
    check("mul_7x6.hold_t40", result, 32'd42);

    do_op("mulh_m1m1",    OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    do_op("mulhu_max",    OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    do_op("mulhsu_m1x2",  OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33);
    do_op("mul_m3x5",     OP_MUL,    32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 33);
    do_op("div_m7d2",     OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    do_op("rem_m7d2",     OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    do_op("div_7dm2",     OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    do_op("rem_7dm2",     OP_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         33);
    do_op("divu_100d7",   OP_DIVU,   32'd100,       32'd7,         32'd14,        33);
    do_op("remu_100d7",   OP_REMU,   32'd100,       32'd7,         32'd2,         33);
    do_op("divu_max_d1",  OP_DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33);
    do_op("divu_by0",     OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    do_op("rem_by0",      OP_REM,    32'd5,         32'd0,         32'd5,         1);
    do_op("div_ovf",      OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("rem_ovf",      OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    // Flush mid-multiply, then restart in the cycle busy drops
    old   = result;
    start = 1'b1;
    op    = OP_MUL;
    a     = 32'd3;
    b     = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    repeat (9) begin
      if (done) ndone++;
      @(negedge clk);
    end
    flush = 1'b1;
    if (done) ndone++;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    if (done) ndone++;
    check("flush.busy_t11", 32'(busy), 32'd0);
    check("flush.no_done", ndone, 0);
    check("flush.result_kept", result, old);
    do_op("mul_2x5_after_flush", OP_MUL, 32'd2, 32'd5, 32'd10, 33);

    // A second start while busy must not disturb the running operation
    start = 1'b1;
    op    = OP_MUL;
    a     = 32'd9;
    b     = 32'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    a     = 32'd2;
    b     = 32'd2;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k     = 6;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("ignored_start.lat", k, 33);
    check("ignored_start.res", result, 32'd81);
    @(negedge clk);
    check("ignored_start.busy_after", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);
    check("ignored_start.not_queued", 32'(busy), 32'd0);

    // start together with flush in IDLE is not accepted
    start = 1'b1;
    flush = 1'b1;
    op    = OP_MUL;
    a     = 32'd4;
    b     = 32'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("start_flush.busy", 32'(busy), 32'd0);
    ndone = 0;
    repeat (40) begin
      if (done || busy) ndone++;
      @(negedge clk);
    end
    check("start_flush.no_activity", ndone, 0);
    check("start_flush.result", result, 32'd81);

    // Reset in mid-operation
    start = 1'b1;
    op    = OP_MUL;
    a     = 32'd7;
    b     = 32'd6;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.done", 32'(done), 32'd0);
    check("midrst.result", result, 32'd0);
    ndone = 0;
    repeat (20) begin
      if (done || busy) ndone++;
      @(negedge clk);
    end
    check("midrst.discarded", ndone, 0);
    do_op("divu_after_rst", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
